// File: rtl/iter_alu.sv
// iter_alu: single-cycle ALU ops plus iterative-latency mult/div writing HI/LO.
module iter_alu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);
  localparam logic [CW-1:0] ML = CW'(MUL_LAT);
  localparam logic [CW-1:0] DL = CW'(DIV_LAT);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic sgn_q, sgn_d, ovf_q, ovf_d, done_q, done_d;
  logic [W:0] sum, diff;
  logic [W-1:0] alu_r, a_mag, b_mag, uq, ur, quo, rem;
  logic alu_v, a_neg, b_neg;
  logic [2*W-1:0] prod;
  assign sum  = {a[W-1], a} + {b[W-1], b};
  assign diff = {a[W-1], a} - {b[W-1], b};
  // Sign-extend only for the signed variants; the low 2W bits are then correct for both.
  assign prod  = {{W{sgn_q & a_q[W-1]}}, a_q} * {{W{sgn_q & b_q[W-1]}}, b_q};
  assign a_neg = sgn_q & a_q[W-1];
  assign b_neg = sgn_q & b_q[W-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign uq    = a_mag / b_mag;
  assign ur    = a_mag % b_mag;
  assign quo   = (a_neg ^ b_neg) ? -uq : uq;
  assign rem   = a_neg ? -ur : ur;
  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (op)
      4'd0:    {alu_v, alu_r} = {sum[W] ^ sum[W-1], sum[W-1:0]};
      4'd1:    {alu_v, alu_r} = {diff[W] ^ diff[W-1], diff[W-1:0]};
      4'd2:    alu_r = a & b;
      4'd3:    alu_r = a | b;
      4'd4:    alu_r = b << (W / 2);
      4'd5:    alu_r = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      4'd6:    alu_r = {{(W-1){1'b0}}, a < b};
      4'd14:   alu_r = hi_q;
      4'd15:   alu_r = lo_q;
      default: alu_r = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        a_d   = a;
        b_d   = b;
        sgn_d = ~op[0];
        cnt_d = CW'(1);
        if (op[3:2] == 2'b10) begin
          state_d = op[1] ? DIV : MUL;
          res_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          res_d  = alu_r;
          ovf_d  = alu_v;
          done_d = 1'b1;
          hi_d   = (op == 4'd12) ? a : hi_q;
          lo_d   = (op == 4'd13) ? a : lo_q;
        end
      end
    end else if (cnt_q == ((state_q == MUL) ? ML : DL)) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b1;
      if (state_q == MUL) {hi_d, lo_d} = prod;
      else if (b_q != '0) {hi_d, lo_d} = {rem, quo};
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
  assign result   = res_q;
  assign overflow = ovf_q;
  assign done     = done_q;
  assign busy     = state_q != IDLE;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: scoreboard bench for iter_alu at WIDTH=32 and WIDTH=16.
module tb_iter_alu;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, start16 = 1'b0;
  logic [3:0] op = '0, op16 = '0;
  logic [31:0] a = '0, b = '0, result, hi, lo;
  logic [15:0] a16 = '0, b16 = '0, result16, hi16, lo16;
  logic overflow, done, busy, ovf16, done16, busy16;
  typedef struct packed {logic [31:0] r; logic ov; logic [31:0] h; logic [31:0] l;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;
  logic [31:0] hm = '0, lm = '0;
  logic [67:0] s_tab [0:15] = '{
    {4'd0, 32'h7FFFFFFF, 32'h00000001}, {4'd1, 32'h80000000, 32'h00000001},
    {4'd0, 32'hFFFFFFFF, 32'h00000001}, {4'd1, 32'h00000005, 32'h00000007},
    {4'd2, 32'hF0F0F0F0, 32'hFF00FF00}, {4'd3, 32'hF0F0F0F0, 32'h0F000000},
    {4'd4, 32'h00000000, 32'h1234ABCD}, {4'd5, 32'hFFFFFFFF, 32'h00000001},
    {4'd6, 32'hFFFFFFFF, 32'h00000001}, {4'd5, 32'h00000001, 32'hFFFFFFFF},
    {4'd7, 32'h00000012, 32'h00000034}, {4'd12, 32'h000000AA, 32'h00000000},
    {4'd14, 32'h00000000, 32'h00000000}, {4'd12, 32'h00000011, 32'h00000000},
    {4'd13, 32'h00000022, 32'h00000000}, {4'd15, 32'h00000000, 32'h00000000}};
  logic [131:0] m_tab [0:7] = '{
    {4'd11, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022},
    {4'd8,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA},
    {4'd9,  32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA},
    {4'd10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    {4'd10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    {4'd11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E},
    {4'd10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
    {4'd8,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000}};
  logic [52:0] w_tab [0:3] = '{
    {4'd4, 16'h0000, 16'h00AB, 1'b0, 16'hAB00},
    {4'd6, 16'h0001, 16'hFFFF, 1'b0, 16'h0001},
    {4'd5, 16'h0001, 16'hFFFF, 1'b0, 16'h0000},
    {4'd0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000}};

  iter_alu dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .overflow(overflow), .done(done), .busy(busy), .hi(hi), .lo(lo));
  iter_alu #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .start(start16), .op(op16),
    .a(a16), .b(b16), .result(result16), .overflow(ovf16), .done(done16), .busy(busy16),
    .hi(hi16), .lo(lo16));

  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [3:0] o, input logic [31:0] x, y);
    logic [31:0] r;
    logic v;
    r = '0;
    v = 1'b0;
    case (o)
      4'd0: begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
      4'd1: begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = {y[15:0], 16'h0000};
      4'd5: r = {31'b0, $signed(x) < $signed(y)};
      4'd6: r = {31'b0, x < y};
      4'd14: r = hm;
      4'd15: r = lm;
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int bc, output bit to);
    bc = 0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin to = 1'b0; break; end
      if (busy) bc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({result, overflow, done, busy, hi, lo} !== '0) begin
      failures++;
      $display("FAIL reset32 got res=%h ov=%b done=%b busy=%b hi=%h lo=%h required all 0", result, overflow, done, busy, hi, lo);
    end
    checks++;
    if ({result16, ovf16, done16, busy16, hi16, lo16} !== '0) begin
      failures++;
      $display("FAIL reset16 got res=%h ov=%b done=%b busy=%b required all 0", result16, ovf16, done16, busy16);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b1; op = 4'd0; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'd11) begin
      failures++;
      $display("FAIL first_after_reset got done=%b res=%h required done=1 res=0000000b", done, result);
    end
  endtask

  task automatic test_single();
    logic [3:0] o;
    logic [31:0] x, y;
    logic [32:0] m;
    int bc;
    bit to;
    for (int i = 0; i < 24; i++) begin
      if (i < 8) begin o = 4'($urandom_range(0, 7)); x = $urandom; y = $urandom; end
      else {o, x, y} = s_tab[i-8];
      m = model(o, x, y);
      if (o == 4'd12) hm = x;
      if (o == 4'd13) lm = x;
      sb.push_back({m[31:0], m[32], hm, lm});
      issue(o, x, y);
      wait_done(bc, to);
      e = sb.pop_front();
      checks++;
      if (to || bc != 0) begin
        failures++;
        $display("FAIL single_latency op=%0d busy_cycles=%0d timeout=%0b required 0 and done", o, bc, to);
      end
      checks++;
      if ({result, overflow, hi, lo} !== {e.r, e.ov, e.h, e.l}) begin
        failures++;
        $display("FAIL single_value op=%0d a=%h b=%h got res=%h ov=%b hi=%h lo=%h required res=%h ov=%b hi=%h lo=%h",
                 o, x, y, result, overflow, hi, lo, e.r, e.ov, e.h, e.l);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL single_done_pulse op=%0d got done=%b required 0", o, done);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [3:0] o;
    logic [31:0] x, y, h, l;
    int bc, lat;
    bit to;
    for (int i = 0; i < 8; i++) begin
      {o, x, y, h, l} = m_tab[i];
      lat = o[1] ? 10 : 5;
      hm = h;
      lm = l;
      sb.push_back({32'h0, 1'b0, hm, lm});
      issue(o, x, y);
      wait_done(bc, to);
      e = sb.pop_front();
      checks++;
      if (to || bc != lat) begin
        failures++;
        $display("FAIL muldiv_latency op=%0d busy_cycles=%0d timeout=%0b required %0d", o, bc, to, lat);
      end
      checks++;
      if ({result, overflow, hi, lo} !== {e.r, e.ov, e.h, e.l}) begin
        failures++;
        $display("FAIL muldiv_value op=%0d a=%h b=%h got res=%h ov=%b hi=%h lo=%h required res=%h ov=%b hi=%h lo=%h",
                 o, x, y, result, overflow, hi, lo, e.r, e.ov, e.h, e.l);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL muldiv_done_pulse op=%0d got done=%b busy=%b required 0 0", o, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    bit to;
    hm = 32'd2;
    lm = 32'd14;
    sb.push_back({32'h0, 1'b0, hm, lm});
    issue(4'd10, 32'd100, 32'd7);
    start = 1'b1; op = 4'd0; a = 32'd5; b = 32'd5;
    wait_done(bc, to);
    e = sb.pop_front();
    checks++;
    if (to || bc != 10) begin
      failures++;
      $display("FAIL busy_ignore_latency busy_cycles=%0d timeout=%0b required 10", bc, to);
    end
    checks++;
    if ({result, overflow, hi, lo} !== {e.r, e.ov, e.h, e.l}) begin
      failures++;
      $display("FAIL busy_ignore_value got res=%h hi=%h lo=%h required res=%h hi=%h lo=%h", result, hi, lo, e.r, e.h, e.l);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 32'd10) begin
      failures++;
      $display("FAIL back_to_back got done=%b busy=%b res=%h required 1 0 0000000a", done, busy, result);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    issue(4'd8, 32'd3, 32'd4);
    repeat (2) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    hm = '0;
    lm = '0;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen |= done; end
    checks++;
    if (seen || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_mid_no_done got done_seen=%b hi=%h lo=%h required 0 0 0", seen, hi, lo);
    end
  endtask

  task automatic test_w16();
    logic [3:0] o;
    logic [15:0] x, y, r;
    logic v;
    for (int i = 0; i < 4; i++) begin
      {o, x, y, v, r} = w_tab[i];
      sb.push_back({16'h0, r, v, 32'h0, 32'h0});
      @(negedge clk);
      start16 = 1'b1; op16 = o; a16 = x; b16 = y;
      @(posedge clk); #1;
      start16 = 1'b0;
      e = sb.pop_front();
      checks++;
      if (done16 !== 1'b1 || busy16 !== 1'b0 || {ovf16, result16, hi16, lo16} !== {e.ov, e.r[15:0], e.h[15:0], e.l[15:0]}) begin
        failures++;
        $display("FAIL w16 op=%0d got done=%b busy=%b ov=%b res=%h required done=1 busy=0 ov=%b res=%h",
                 o, done16, busy16, ovf16, result16, e.ov, e.r[15:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_muldiv();
    test_back_to_back();
    test_reset_mid();
    test_w16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter MUL_LAT, default 5, multiply busy cycles (>=1).
REQ-003 SHALL have parameter DIV_LAT, default 10, divide busy cycles (>=1).
REQ-004 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-006 SHALL have port start input 1: request, op/a/b sampled when start=1 and busy=0.
REQ-007 SHALL have port op input 4: operation code per REQ-012.
REQ-008 SHALL have ports a, b input WIDTH: operands.
REQ-009 SHALL have ports result output WIDTH, overflow output 1, done output 1, busy output 1.
REQ-010 SHALL have ports hi, lo output WIDTH: current HI/LO register values.

Function
REQ-011 SHALL accept a request only on an edge with start=1 and busy=0; start while busy ignored, no queueing.
REQ-012 SHALL decode op: 0 add, 1 sub, 2 and, 3 or, 4 b<<(WIDTH/2), 5 slt signed, 6 sltu, 7 reserved (result 0), 8 mult, 9 multu, 10 div, 11 divu, 12 mthi, 13 mtlo, 14 mfhi, 15 mflo.
REQ-013 SHALL complete ops 0-7, 12-15 in one cycle: result/overflow registered at acceptance edge, done=1 for the following cycle only, busy stays 0.
REQ-014 SHALL compute add/sub modulo 2^WIDTH; overflow=1 iff signed two's-complement overflow (WIDTH+1-bit sign-extended sum bits MSB and MSB-1 differ); overflow=0 for all other ops.
REQ-015 SHALL write wrapped add/sub result even on overflow (flag only, no trap).
REQ-016 SHALL set slt/sltu result to zero-extended 1-bit compare.
REQ-017 SHALL for mthi/mtlo load hi/lo from a at acceptance edge, result=0; mfhi/mflo return hi/lo value before that edge.
REQ-018 SHALL implement states IDLE, MUL, DIV; IDLE->MUL on accepted op 8/9, IDLE->DIV on accepted op 10/11, MUL/DIV->IDLE when cycle counter reaches latency.
REQ-019 SHALL assert busy=1 in MUL/DIV: for MUL exactly MUL_LAT cycles after acceptance edge, DIV exactly DIV_LAT cycles.
REQ-020 SHALL at the final edge of MUL/DIV update hi/lo, clear busy, pulse done one cycle; result=0, overflow=0 for these ops.
REQ-021 SHALL for mult/multu form 2*WIDTH-bit product (signed/unsigned), hi=upper WIDTH bits, lo=lower.
REQ-022 SHALL for div/divu set lo=quotient, hi=remainder; signed quotient truncates toward zero, remainder takes sign of dividend.
REQ-023 SHALL for signed div of most-negative by -1 set lo=most-negative, hi=0.
REQ-024 SHALL for divide by zero leave hi/lo unchanged, still run DIV_LAT cycles and pulse done.
REQ-025 SHALL latch operands at acceptance; input changes during busy do not affect outcome.
REQ-026 SHALL allow a new request on the same edge busy falls is NOT accepted (busy=1 before edge); next request accepted the cycle after done.
REQ-027 SHALL hold result and overflow stable until the next accepted single-cycle op.

Reset
REQ-028 SHALL on reset asynchronously force IDLE, counter 0, busy=0, done=0, result=0, overflow=0, hi=0, lo=0.
REQ-029 SHALL on reset mid-MUL/DIV abort operation, discard pending hi/lo update, no done pulse.
REQ-030 SHALL accept first request on first rising edge after reset deasserts.

Verification
REQ-031 SHALL verify (WIDTH=32) add a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, done one cycle, busy=0.
REQ-032 SHALL verify mult a=0xFFFFFFFE b=3 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA; multu same -> hi=0x00000002 lo=0xFFFFFFFA.
REQ-033 SHALL verify div a=-7 b=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div a=0x80000000 b=-1 -> lo=0x80000000 hi=0.
REQ-034 SHALL verify divu b=0 with hi=0x11 lo=0x22 preloaded via mthi/mtlo -> hi/lo unchanged, done pulses after 10 cycles.
REQ-035 SHALL verify start with op=0 during DIV busy ignored, and reset asserted at busy cycle 3 of mult -> busy=0, hi=lo=0, no done.
REQ-036 SHALL verify WIDTH=16: op 4 b=0x00AB -> result 0xAB00; sltu a=1 b=0xFFFF -> 1, slt same -> 0.
